// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the display pipeline: default 640x480 @ 60 Hz
// timing, coordinate widths and helpers that derive totals and sync windows.
package vga_timing_pkg;

  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 16;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Total positions on one axis (visible + porches + sync).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First position inside the sync pulse.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First position after the sync pulse (exclusive bound).
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus registered decode of the
// sync window and the visible region. Decode is taken from the next count so
// the flags change on the same edge as the count itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int ACTIVE     = 640
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               in_sync,
  output logic               in_active
);

  localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] SS     = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SE     = COORD_W'(SYNC_END);
  localparam logic [COORD_W-1:0] ACT_HI = COORD_W'(ACTIVE);

  logic [COORD_W-1:0] count_next;

  // wrap marks the enabled step that returns the count to zero
  assign wrap = en && (count == LAST);

  // next count: hold, step, or wrap at the last position
  always_comb begin
    count_next = count;
    if (en) begin
      count_next = (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // count and decoded flags, all updated on the same edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      in_sync   <= 1'b0;
      in_active <= 1'b1;
    end else begin
      count     <= count_next;
      in_sync   <= (count_next >= SS) && (count_next < SE);
      in_active <= (count_next < ACT_HI);
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Raster scan generator: pixel-clock enable from the system clock, h/v
// position counters, blank, sync pulses, and frame strobe/counter.
// pixel_tick is high for one clock per pixel period; positions advance on the
// edge that ends a pixel_tick clock, so all position outputs hold for CLK_DIV
// clocks and change together.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   pixel_tick,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic                   blank,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             h_wrap, h_in_sync, h_in_active;
  logic             v_wrap, v_in_sync, v_in_active;

  // pixel divider; the tick is registered so it is low throughout reset and
  // lands in clock CLK_DIV after release
  always_ff @(posedge clk) begin
    if (!reset) begin
      div        <= '0;
      pixel_tick <= 1'b0;
    end else begin
      pixel_tick <= (div == DIV_LAST);
      div        <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (sync_start(H_ACTIVE, H_FP)),
    .SYNC_END   (sync_end(H_ACTIVE, H_FP, H_SYNC)),
    .ACTIVE     (H_ACTIVE)
  ) u_h (
    .clk       (clk),
    .reset     (reset),
    .en        (pixel_tick),
    .count     (x),
    .wrap      (h_wrap),
    .in_sync   (h_in_sync),
    .in_active (h_in_active)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (sync_start(V_ACTIVE, V_FP)),
    .SYNC_END   (sync_end(V_ACTIVE, V_FP, V_SYNC)),
    .ACTIVE     (V_ACTIVE)
  ) u_v (
    .clk       (clk),
    .reset     (reset),
    .en        (h_wrap),
    .count     (y),
    .wrap      (v_wrap),
    .in_sync   (v_in_sync),
    .in_active (v_in_active)
  );

  // outputs are pure functions of registered flags, so they share one edge
  assign blank       = !(h_in_active && v_in_active);
  assign hsync       = h_in_sync ? SYNC_ACTIVE : !SYNC_ACTIVE;
  assign vsync       = v_in_sync ? SYNC_ACTIVE : !SYNC_ACTIVE;
  // high during the tick clock whose closing edge enters (0,0)
  assign frame_start = v_wrap;

  // completed-frame counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (v_wrap) begin
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Produces the raster scan that drives every per-pixel block in the display pipeline: pixel coordinates `x`/`y`, `blank`, and the monitor sync pulses `hsync`/`vsync`. It also emits one-clock pixel and frame strobes. It runs from the 100 MHz system clock with a pixel-clock enable and defaults to 640x480 @ 60 Hz. Collider, trigger, border, UI and player generators and the final RGB renderer all consume its outputs, so the colour output is aligned to the sync pulses it drives.

## Interface
Parameters:
- `CLK_DIV`, default 4: system clocks per pixel, minimum 1.
- `H_ACTIVE`, default 640; `H_FP`, default 16; `H_SYNC`, default 96; `H_BP`, default 48: horizontal timing in pixels.
- `V_ACTIVE`, default 480; `V_FP`, default 10; `V_SYNC`, default 2; `V_BP`, default 33: vertical timing in lines.
- `SYNC_ACTIVE`, default 0: asserted level of `hsync`/`vsync`.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: reset, synchronous, active-low.
- `pixel_tick` out 1: one-clock strobe, once per pixel period.
- `x` out 10: horizontal count, 0..H_TOTAL-1.
- `y` out 10: vertical count, 0..V_TOTAL-1.
- `blank` out 1: high when `x`>=H_ACTIVE or `y`>=V_ACTIVE.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `frame_start` out 1: one-clock strobe when the position enters (0,0).
- `frame_count` out 16: count of completed frames, wraps.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults). V_TOTAL is formed the same way (525 at defaults).
- Divider `div` counts 0..CLK_DIV-1, then wraps to 0. `pixel_tick`=1 on the clock where `div`==CLK_DIV-1. With CLK_DIV=1, `pixel_tick` is constantly 1 after reset.
- On each tick, `h` increments. When `h`==H_TOTAL-1, `h` goes to 0 and `v` increments. When `v`==V_TOTAL-1 at the same time, `v` goes to 0.
- Decode of `x`/`y`/`blank`/`hsync`/`vsync` is taken from the next-state `h`/`v` and registered. All outputs change on the same edge as the counters, with no skew between the signals.
- `hsync`=SYNC_ACTIVE when H_ACTIVE+H_FP <= `h` < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults), otherwise inverted.
- `vsync`=SYNC_ACTIVE when V_ACTIVE+V_FP <= `v` < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults), otherwise inverted.
- On the tick that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0): `frame_start`=1 for one clock and `frame_count` increments. 65535 wraps to 0.

## Timing
- Reset is sampled only on the `clk` edge. While `reset`==0, on each edge: `div`=0, `h`=0, `v`=0, `x`=0, `y`=0, `blank`=0, `hsync`=`vsync`=!SYNC_ACTIVE, `pixel_tick`=0, `frame_start`=0, `frame_count`=0.
- A reset asserted mid-frame takes effect on the next edge regardless of `div`, `h` or `v`. No partial-frame `frame_start` is emitted.
- After the first edge with `reset`==1, the first `pixel_tick` is high during clock CLK_DIV. The outputs advance to `x`=1 at the end of that clock.
- Outputs hold for exactly CLK_DIV clocks between changes. Downstream logic may sample them on any clock.
- `frame_start` coincides with the `pixel_tick` clock that enters (0,0) and goes low on the next clock.
- Frame period = CLK_DIV*H_TOTAL*V_TOTAL clocks (1,680,000 at defaults).
- Downstream combinational colour logic adds 0 cycles. Any registered renderer stage adds 1 clock, and the team delays `hsync`/`vsync` externally to match.

## Structure
- Package `vga_timing_pkg` holds the default 640x480 constants, H_TOTAL/V_TOTAL derivation, and the sync-window bounds, shared with the renderer and object generators.
- Sub-module `vga_axis_counter` is instantiated twice, for `h` and for `v`. Its inputs are `clk`, `reset`, `en`, TOTAL/SYNC_START/SYNC_END/ACTIVE. Its outputs are the count, a `wrap` flag, `in_sync` and `in_active`. The `h` instance's `wrap` drives the `v` instance's `en`.

## Test plan
- Reset held 3 clocks with defaults: all outputs at their reset values, including `hsync`=`vsync`=1; `frame_count`=0.
- Release reset: `pixel_tick` pulses at clocks 4, 8, 12…; `x` steps 0→1→2 every 4 clocks; `blank`=0.
- Run one line: `hsync`=0 exactly for `x` 656..751; `blank`=1 from `x`=640; after `x`=799, `x`=0 and `y`=1.
- Run a full frame: `vsync`=0 exactly for `y`=490..491; `frame_start` is a single pulse at clock 1,680,000 after the first tick period; `frame_count` goes 0→1.
- Assert reset at `x`=300, `y`=200 for 1 clock: the next clock shows `x`=0, `y`=0, `frame_count`=0, with no `frame_start`.
- CLK_DIV=1, SYNC_ACTIVE=1: `pixel_tick` is constantly high; `hsync`=1 for `x` 656..751; frame period is 420,000 clocks.
